// File: rtl/serial_to_paral.sv
// Serial-to-parallel receiver for the 8-bit LSB-first link: hunts for the
// bit-7 sync marker, qualifies lock over LOCK_FRAMES frames, then emits bytes.
module serial_to_paral #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_sdata,
  input  logic       i_sync,
  output logic [7:0] o_pdata,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_locked
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] pdata_q, pdata_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       locked_q, locked_d;

  logic       frame_end;
  logic       good_frame;
  logic       early_sync;
  logic [3:0] good_inc;

  assign frame_end  = (bit_cnt_q == 3'd7);
  assign good_frame = frame_end & i_sync;
  assign early_sync = i_sync & ~frame_end;
  assign good_inc   = good_cnt_q + 4'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= HUNT;
      bit_cnt_q  <= 3'd0;
      good_cnt_q <= 4'd0;
      shreg_q    <= 7'd0;
      pdata_q    <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      good_cnt_q <= good_cnt_d;
      shreg_q    <= shreg_d;
      pdata_q    <= pdata_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_en) begin
      case (state_q)
        HUNT: begin
          if (i_sync) state_d = CHECK;
        end
        CHECK: begin
          if (frame_end && !i_sync)                   state_d = HUNT;
          else if (good_frame && (good_inc == LOCK_N)) state_d = LOCKED;
        end
        LOCKED: begin
          if (frame_end && !i_sync) state_d = HUNT;
          else if (early_sync)      state_d = CHECK;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath and strobes; with i_en low everything holds and strobes drop.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    good_cnt_d = good_cnt_q;
    shreg_d    = shreg_q;
    pdata_d    = pdata_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    locked_d   = (state_d == LOCKED);
    if (i_en) begin
      case (state_q)
        HUNT: begin
          if (i_sync) begin
            bit_cnt_d  = 3'd0;
            good_cnt_d = 4'd0;
          end
        end
        CHECK, LOCKED: begin
          shreg_d   = {i_sdata, shreg_q[6:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (early_sync) begin
            bit_cnt_d  = 3'd0;
            good_cnt_d = 4'd0;
            err_d      = (state_q == LOCKED);
          end else if (good_frame) begin
            if (state_q == CHECK) begin
              good_cnt_d = (good_inc == LOCK_N) ? 4'd0 : good_inc;
            end else begin
              pdata_d = {i_sdata, shreg_q};
              valid_d = 1'b1;
            end
          end else if (frame_end) begin
            err_d = (state_q == LOCKED);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pdata  = pdata_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_serial_to_paral.sv
// Directed bench for serial_to_paral: lock acquisition, byte order, framing
// errors, enable stalls and asynchronous reset, with a byte scoreboard.
module tb_serial_to_paral;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       sdata = 1'b0;
  logic       sync  = 1'b0;
  logic [7:0] o_pdata;
  logic       o_valid;
  logic       o_err;
  logic       o_locked;

  int n_tests = 0;
  int n_fail  = 0;
  int v_cnt   = 0;
  int e_cnt   = 0;
  int cyc     = 0;
  int last_v_cyc = 0;
  logic [7:0] exp_q[$];

  serial_to_paral #(.LOCK_FRAMES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_sdata (sdata),
    .i_sync  (sync),
    .o_pdata (o_pdata),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enabled or stalled sample; outputs are observed 1 ns after the edge.
  task automatic tick(input logic d, input logic s, input logic e = 1'b1);
    @(negedge clk);
    sdata = d;
    sync  = s;
    en    = e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_valid) begin
      v_cnt++;
      last_v_cyc = cyc;
    end
    if (o_err) e_cnt++;
    if (o_valid && o_err) check("valid_err_excl", 32'(o_valid & o_err), 0);
    if (o_valid) begin
      check("sb_has_exp", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_pdata", 32'(o_pdata), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s7 = 1'b1);
    for (int i = 0; i < 8; i++) tick(b[i], (i == 7) && s7);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pdata",  32'(o_pdata), 32'h00);
    check("rst_valid",  32'(o_valid), 0);
    check("rst_err",    32'(o_err), 0);
    check("rst_locked", 32'(o_locked), 0);
    rst_n = 1'b1;
  endtask

  // HUNT sync, two CHECK frames, then the first delivered byte.
  task automatic lock_up(input logic [7:0] b);
    int v0;
    v0 = v_cnt;
    send_byte(b);
    check("lock_sync1", 32'(o_locked), 0);
    send_byte(b);
    check("lock_sync2", 32'(o_locked), 0);
    send_byte(b);
    check("lock_sync3", 32'(o_locked), 1);
    check("lock_no_valid", 32'(v_cnt - v0), 0);
    exp_q.push_back(b);
    send_byte(b);
    check("first_valid", 32'(o_valid), 1);
    check("first_pdata", 32'(o_pdata), 32'(b));
    exp_q.push_back(b);
    send_byte(b);
    check("second_valid", 32'(o_valid), 1);
    check("lock_valid_cnt", 32'(v_cnt - v0), 2);
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] b;
    int v0, e0, c0;
    seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'hFF; seq[3] = 8'h00; seq[4] = 8'h96;

    // Scenario 1: acquisition from reset
    do_reset();
    lock_up(8'hA5);

    // Scenario 2: LSB-first ordering of distinct bytes
    for (int k = 0; k < 5; k++) begin
      v0 = v_cnt;
      exp_q.push_back(seq[k]);
      send_byte(seq[k]);
      check("seq_valid", 32'(o_valid), 1);
      check("seq_pdata", 32'(o_pdata), 32'(seq[k]));
      check("seq_one_valid", 32'(v_cnt - v0), 1);
    end

    // Scenario 3: missing sync at bit 7 while locked
    v0 = v_cnt;
    e0 = e_cnt;
    send_byte(8'h3C, 1'b0);
    check("nosync_err", 32'(o_err), 1);
    check("nosync_locked", 32'(o_locked), 0);
    check("nosync_valid", 32'(o_valid), 0);
    check("nosync_pdata", 32'(o_pdata), 32'h96);
    send_byte(8'h11);
    check("relock_a", 32'(o_locked), 0);
    check("err_one_cycle", 32'(o_err), 0);
    send_byte(8'h22);
    check("relock_b", 32'(o_locked), 0);
    send_byte(8'h33);
    check("relock_c", 32'(o_locked), 1);
    check("relock_no_valid", 32'(v_cnt - v0), 0);
    check("nosync_err_cnt", 32'(e_cnt - e0), 1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    check("relock_pdata", 32'(o_pdata), 32'h5A);

    // Scenario 4: early sync at bit_cnt 3 while locked
    e0 = e_cnt;
    v0 = v_cnt;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("early_err", 32'(o_err), 1);
    check("early_locked", 32'(o_locked), 0);
    send_byte(8'h44);
    check("early_relock_a", 32'(o_locked), 0);
    send_byte(8'h55);
    check("early_relock_b", 32'(o_locked), 1);
    check("early_pdata_held", 32'(o_pdata), 32'h5A);
    check("early_err_cnt", 32'(e_cnt - e0), 1);
    check("early_no_valid", 32'(v_cnt - v0), 0);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    check("early_after_pdata", 32'(o_pdata), 32'hC3);

    // Scenario 5: five-cycle enable stall mid-frame
    b  = 8'h6B;
    v0 = v_cnt;
    e0 = e_cnt;
    c0 = cyc;
    exp_q.push_back(b);
    for (int i = 0; i < 4; i++) tick(b[i], 1'b0);
    for (int i = 0; i < 5; i++) tick(b[4], 1'b0, 1'b0);
    check("stall_no_valid", 32'(v_cnt - v0), 0);
    check("stall_no_err", 32'(e_cnt - e0), 0);
    check("stall_locked", 32'(o_locked), 1);
    for (int i = 4; i < 8; i++) tick(b[i], i == 7);
    check("stall_valid", 32'(o_valid), 1);
    check("stall_pdata", 32'(o_pdata), 32'h6B);
    check("stall_latency", 32'(last_v_cyc - c0), 13);

    // Scenario 6: asynchronous reset mid-frame while locked
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pdata",  32'(o_pdata), 32'h00);
    check("arst_locked", 32'(o_locked), 0);
    check("arst_valid",  32'(o_valid), 0);
    check("arst_err",    32'(o_err), 0);
    do_reset();
    lock_up(8'hA5);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
